// File: rtl/alu_pkg.sv
// Shared opcode constants and control states for the iterative ALU.
// Pure declarations: no latency, no backpressure.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: start edge performs bit 0, then one bit per edge; done after WIDTH edges.
// No backpressure: the caller captures prod_o on the done_o edge; abort_i drops the operation.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o   = busy_q && (cnt_q == LAST);
  assign prod_o   = acc_step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort_i) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      // Bit 0 is folded into the start edge so the whole product takes WIDTH edges.
      mcand_q  <= a_i << 1;
      mplier_q <= b_i >> 1;
      acc_q    <= b_i[0] ? a_i : '0;
      cnt_q    <= CNT_W'(1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == LAST) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Valid/ready ALU: single-edge logic/arith ops, WIDTH-edge iterative multiply, result held until ready_i.
// Accepts only in IDLE (ready_o); flush_i aborts any operation and beats accept/ready_i.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             Ovf_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum, diff, alu_res, mul_prod, res_d;
  logic             alu_ovf, ovf_d, res_load, mul_start, mul_done;
  logic [WIDTH-1:0] data_q;
  logic             zero_q, ovf_q;

  assign sum  = data1_i + data2_i;
  assign diff = data1_i - data2_i;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (sum[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (diff[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_SLTU: alu_res[0] = data1_i < data2_i;
      OP_SLT:  alu_res[0] = $signed(data1_i) < $signed(data2_i);
      default: alu_res = '0;
    endcase
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    res_load  = 1'b0;
    res_d     = alu_res;
    ovf_d     = alu_ovf;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            res_load  = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          res_load = 1'b1;
          res_d    = mul_prod;
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush discards the operation; the previously delivered result stays visible.
    if (flush_i) begin
      state_d   = ST_IDLE;
      mul_start = 1'b0;
      res_load  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (res_load) begin
        data_q <= res_d;
        zero_q <= (res_d == '0);
        ovf_q  <= ovf_d;
      end
    end
  end

  assign data_o = data_q;
  assign Zero_o = zero_q;
  assign Ovf_o  = ovf_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mul_start),
    .abort_i (flush_i),
    .a_i     (data1_i),
    .b_i     (data2_i),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

endmodule
